// File: rtl/c7bifu_pfgen.sv
// Prefetch-address generator and in-order fetch tracker for the IFU front end.
// Issues sequential fetches, redirects on except/ertn/branch, squashes stale responses.
module c7bifu_pfgen #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       FETCH_BYTES = 8,
  parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(32'h1c00_0000),
  parameter int unsigned       MAX_OUT     = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  output logic              o_ifu_icu_req_ic1,
  output logic [ADDR_W-1:0] o_ifu_icu_addr_ic1,
  input  logic              i_icu_ifu_ack_ic1,
  input  logic              i_icu_ifu_data_valid_ic2,
  input  logic              i_ibuf_ifu_stall,
  input  logic              i_exu_ifu_except,
  input  logic [ADDR_W-1:0] i_exu_ifu_isr_addr,
  input  logic              i_exu_ifu_ertn,
  input  logic [ADDR_W-1:0] i_exu_ifu_ert_addr,
  input  logic              i_exu_ifu_branch,
  input  logic [ADDR_W-1:0] i_exu_ifu_brn_addr,
  output logic              o_ifu_fetch_valid_ic2,
  output logic [ADDR_W-1:0] o_ifu_fetch_pc_ic2
);

  localparam int unsigned       CNT_W      = $clog2(MAX_OUT + 1);
  localparam int unsigned       PTR_W      = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(FETCH_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(STEP - ADDR_W'(1));
  localparam logic [CNT_W-1:0]  MAX_CNT    = CNT_W'(MAX_OUT);
  localparam logic [PTR_W-1:0]  LAST_PTR   = PTR_W'(MAX_OUT - 1);

  typedef enum logic {StInit, StRun} state_e;

  state_e              r_state;
  state_e              w_state_next;
  logic [ADDR_W-1:0]   r_pf_addr;
  logic [ADDR_W-1:0]   w_pf_addr_next;
  logic [CNT_W-1:0]    r_outst_cnt;
  logic [CNT_W-1:0]    w_outst_cnt_next;
  logic [CNT_W-1:0]    r_kill_cnt;
  logic [CNT_W-1:0]    w_kill_cnt_next;
  logic [ADDR_W-1:0]   r_pc_fifo [MAX_OUT];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;

  logic                w_redir;
  logic [ADDR_W-1:0]   w_target;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_req;
  logic                w_acc;
  logic                w_pop;
  logic                w_live;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= StInit;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StInit:  w_state_next = StRun;
      StRun:   w_state_next = StRun;
      default: w_state_next = StInit;
    endcase
  end

  // Exception outranks ertn, which outranks branch.
  always_comb begin
    w_redir = i_exu_ifu_except | i_exu_ifu_ertn | i_exu_ifu_branch;
    if (i_exu_ifu_except) begin
      w_target = i_exu_ifu_isr_addr;
    end else if (i_exu_ifu_ertn) begin
      w_target = i_exu_ifu_ert_addr;
    end else begin
      w_target = i_exu_ifu_brn_addr;
    end
  end

  always_comb begin
    w_addr = w_redir ? w_target : r_pf_addr;
    w_req  = (r_state == StRun) & ~i_ibuf_ifu_stall & (r_outst_cnt < MAX_CNT);
    w_acc  = w_req & i_icu_ifu_ack_ic1;
    w_pop  = i_icu_ifu_data_valid_ic2 & (r_outst_cnt != '0);
    w_live = w_pop & (r_kill_cnt == '0) & ~w_redir;
  end

  // A redirect that cannot issue this cycle is parked in the prefetch register.
  always_comb begin
    w_pf_addr_next = r_pf_addr;
    if (w_acc) begin
      w_pf_addr_next = (w_addr & ALIGN_MASK) + STEP;
    end else if (w_redir) begin
      w_pf_addr_next = w_target;
    end
  end

  // Everything in flight before a redirect is stale; the redirect's own fetch is not.
  always_comb begin
    w_outst_cnt_next = r_outst_cnt + CNT_W'(w_acc) - CNT_W'(w_pop);
    w_kill_cnt_next  = r_kill_cnt;
    if (w_redir) begin
      w_kill_cnt_next = r_outst_cnt - CNT_W'(w_pop);
    end else if (w_pop && (r_kill_cnt != '0)) begin
      w_kill_cnt_next = r_kill_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pf_addr   <= RESET_PC;
      r_outst_cnt <= '0;
      r_kill_cnt  <= '0;
    end else begin
      r_pf_addr   <= w_pf_addr_next;
      r_outst_cnt <= w_outst_cnt_next;
      r_kill_cnt  <= w_kill_cnt_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < MAX_OUT; i++) begin
        r_pc_fifo[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_acc) begin
        r_pc_fifo[r_wr_ptr] <= w_addr;
        r_wr_ptr            <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
      end
    end
  end

  assign o_ifu_icu_req_ic1     = w_req;
  assign o_ifu_icu_addr_ic1    = w_addr;
  assign o_ifu_fetch_valid_ic2 = w_live;
  assign o_ifu_fetch_pc_ic2    = r_pc_fifo[r_rd_ptr];

endmodule
